pipe_perf_monitor: RTL and testbench

//   Synthesisable pipeline performance monitor for the 5-stage CPU. Counts qualified

---
 rtl/perf_pkg.sv | 25 ++
 rtl/perf_counter.sv | 56 +++++
 rtl/pipe_perf_monitor.sv | 104 ++++++++++
 tb/tb_pipe_perf_monitor.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Package: perf_pkg
// Shared types and constants for the pipeline performance monitor.
//   state_e    : monitor FSM states (IDLE, RUN, DONE)
//   EV_STALL / EV_FLUSH : conventional event channel indices on event_i
//   sel_width(): width of the read-select port for a given channel count
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NUM_EVENTS_DEF = 4;
    localparam int SEL_W          = $clog2(NUM_EVENTS_DEF + 1);

    localparam int EV_STALL = 0;
    localparam int EV_FLUSH = 1;

    // Select covers NUM_EVENTS event counters plus the cycle counter.
    function automatic int sel_width(input int num_events);
        return $clog2(num_events + 1);
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Module: perf_counter
// One CNT_W-bit event counter with sticky overflow flag.
//   clk_i  in  clock
//   rst_i  in  async reset, active-high
//   clr_i  in  synchronous clear (wins over inc_i)
//   inc_i  in  increment request for this edge
//   cnt_o  out current count
//   ovf_o  out sticky overflow (increment seen while count was all-ones)
module perf_counter #(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             at_max;

    assign at_max = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (at_max) begin
                ovf_d = 1'b1;
                cnt_d = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Module: pipe_perf_monitor
// Pipeline performance monitor: counts qualified hazard events per channel and
// elapsed run cycles, stopping itself once the cycle budget is consumed.
//   clk_i, rst_i     clock / async active-high reset
//   start_i          level enable, low pauses counting while in RUN
//   clear_i          sync clear of counters/flags, returns to IDLE
//   event_i          raw per-channel events
//   inhibit_i        per-channel qualifier (event ignored when high)
//   rd_sel_i         0..NUM_EVENTS-1 event counters, NUM_EVENTS cycle counter
//   rd_data_o        registered read data (1-cycle latency, 0 if out of range)
//   running_o/done_o decoded from registered state
//   ovf_o            sticky overflow flags, MSB = cycle counter
module pipe_perf_monitor
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 64,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic                              clear_i,
    input  logic [NUM_EVENTS-1:0]             event_i,
    input  logic [NUM_EVENTS-1:0]             inhibit_i,
    input  logic [sel_width(NUM_EVENTS)-1:0]  rd_sel_i,
    output logic [CNT_W-1:0]                  rd_data_o,
    output logic                              running_o,
    output logic                              done_o,
    output logic [NUM_EVENTS:0]               ovf_o
);

    localparam logic [CNT_W:0] BUDGET = (CNT_W+1)'(MAX_CYCLES);

    state_e state_q, state_d;
    logic   en;
    logic   budget_hit;

    logic [NUM_EVENTS:0]            inc;
    logic [NUM_EVENTS:0][CNT_W-1:0] cnt;
    logic [NUM_EVENTS:0]            ovf;
    logic [CNT_W:0]                 cyc_nxt;
    logic [CNT_W-1:0]               rd_data_q, rd_data_d;

    assign en = (state_q == RUN) && start_i && !clear_i;

    // Extra bit so the compare never aliases on counter wrap.
    assign cyc_nxt    = {1'b0, cnt[NUM_EVENTS]} + 1'b1;
    assign budget_hit = (MAX_CYCLES != 0) && en && (cyc_nxt == BUDGET);

    assign inc[NUM_EVENTS]        = en;
    assign inc[NUM_EVENTS-1:0]    = {NUM_EVENTS{en}} & event_i & ~inhibit_i;

    // Channels 0..NUM_EVENTS-1 are events, the last instance is the cycle counter.
    for (genvar g = 0; g <= NUM_EVENTS; g++) begin : g_cnt
        perf_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clear_i),
            .inc_i (inc[g]),
            .cnt_o (cnt[g]),
            .ovf_o (ovf[g])
        );
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i)    state_d = RUN;
                RUN:     if (budget_hit) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (int'(rd_sel_i) <= NUM_EVENTS) rd_data_d = cnt[rd_sel_i];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign running_o = (state_q == RUN);
    assign done_o    = (state_q == DONE);
    assign ovf_o     = ovf;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
module tb_pipe_perf_monitor;
    import perf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, clear;
    logic [3:0]  ev, inh;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic        running, done;
    logic [4:0]  ovf;

    // Small-width instances for overflow behaviour (1 channel, no budget).
    logic        s_start, s_clear, s_ev, s_inh, s_sel;
    logic [3:0]  sat_data, wrp_data;
    logic        sat_run, sat_done, wrp_run, wrp_done;
    logic [1:0]  sat_ovf, wrp_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_perf_monitor #(.NUM_EVENTS(4), .CNT_W(32), .MAX_CYCLES(64), .SATURATE(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .event_i(ev), .inhibit_i(inh), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
        .running_o(running), .done_o(done), .ovf_o(ovf));

    pipe_perf_monitor #(.NUM_EVENTS(1), .CNT_W(4), .MAX_CYCLES(0), .SATURATE(1'b1)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .clear_i(s_clear),
        .event_i(s_ev), .inhibit_i(s_inh), .rd_sel_i(s_sel), .rd_data_o(sat_data),
        .running_o(sat_run), .done_o(sat_done), .ovf_o(sat_ovf));

    pipe_perf_monitor #(.NUM_EVENTS(1), .CNT_W(4), .MAX_CYCLES(0), .SATURATE(1'b0)) dut_wrp (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .clear_i(s_clear),
        .event_i(s_ev), .inhibit_i(s_inh), .rd_sel_i(s_sel), .rd_data_o(wrp_data),
        .running_o(wrp_run), .done_o(wrp_done), .ovf_o(wrp_ovf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [2:0] s, input logic [31:0] exp, input string tag);
        rd_sel = s;
        @(negedge clk);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; ev = '0; inh = '0; rd_sel = '0;
        s_start = 1'b0; s_clear = 1'b0; s_ev = 1'b0; s_inh = 1'b0; s_sel = 1'b0;
        cyc(2);
        rst = 1'b0;

        // 1. Reset / idle: events present but never started.
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {27'd0, ovf}, 32'd0);
        chk("rst_rdata", rd_data, 32'd0);
        ev = 4'hF;
        cyc(10);
        chk("idle_running", {31'd0, running}, 32'd0);
        for (int s = 0; s <= 4; s++) rd(3'(s), 32'd0, "idle_rd");

        // 2. Budget stop: 1 transition edge + 64 counted edges.
        ev = 4'b0001; start = 1'b1;
        cyc(65);
        chk("bud_done", {31'd0, done}, 32'd1);
        chk("bud_running", {31'd0, running}, 32'd0);
        cyc(3);
        rd(3'd4, 32'd64, "bud_cycle");
        rd(3'd0, 32'd64, "bud_ch0");
        rd(3'd1, 32'd0, "bud_ch1");
        chk("bud_ovf", {27'd0, ovf}, 32'd0);

        // 3. Qualification.
        start = 1'b0; clear = 1'b1; ev = '0;
        cyc(1);
        clear = 1'b0;
        chk("clr_done", {31'd0, done}, 32'd0);
        rd(3'd0, 32'd0, "clr_ch0");
        start = 1'b1;
        cyc(1);
        chk("q_running", {31'd0, running}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            ev[EV_STALL]  = 1'b1;
            inh[EV_STALL] = (i == 2 || i == 4 || i == 6);
            ev[EV_FLUSH]  = (i == 1 || i == 7);
            cyc(1);
        end
        start = 1'b0; ev = '0; inh = '0;
        rd(3'd0, 32'd7, "q_ch0");
        rd(3'd1, 32'd2, "q_ch1");
        rd(3'd4, 32'd10, "q_cycle");

        // 4. Pause then resume; clear wins over start/events.
        cyc(5);
        chk("p_running", {31'd0, running}, 32'd1);
        rd(3'd4, 32'd10, "p_cycle_paused");
        start = 1'b1;
        cyc(4);
        start = 1'b0;
        rd(3'd4, 32'd14, "p_cycle_resume");
        start = 1'b1; clear = 1'b1; ev = 4'hF;
        cyc(1);
        clear = 1'b0; start = 1'b0; ev = '0;
        chk("c_running", {31'd0, running}, 32'd0);
        rd(3'd0, 32'd0, "c_ch0");
        rd(3'd4, 32'd0, "c_cycle");

        // 5. Overflow on 4-bit counters: 20 events.
        s_start = 1'b1; s_ev = 1'b1;
        cyc(21);
        s_start = 1'b0; s_ev = 1'b0; s_sel = 1'b0;
        cyc(1);
        chk("sat_ch0", {28'd0, sat_data}, 32'd15);
        chk("wrp_ch0", {28'd0, wrp_data}, 32'd4);
        chk("sat_ovf", {30'd0, sat_ovf}, 32'd3);
        chk("wrp_ovf", {30'd0, wrp_ovf}, 32'd3);
        s_sel = 1'b1;
        cyc(1);
        chk("sat_cycle", {28'd0, sat_data}, 32'd15);
        chk("wrp_cycle", {28'd0, wrp_data}, 32'd4);

        // 6. Async reset mid-run at cycle 30, between edges.
        rd_sel = 3'd4; start = 1'b1;
        cyc(31);
        chk("r_pre_cycle", rd_data, 32'd29);
        #2 rst = 1'b1;
        #1;
        chk("r_running", {31'd0, running}, 32'd0);
        chk("r_rdata", rd_data, 32'd0);
        chk("r_ovf_small", {30'd0, sat_ovf}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd(3'd4, 32'd0, "r_cycle_cleared");
        start = 1'b1;
        cyc(4);
        start = 1'b0;
        rd(3'd4, 32'd3, "r_cycle_new");
        rd(3'd5, 32'd0, "oor_sel5");
        rd(3'd4, 32'd3, "r_cycle_again");
        rd(3'd7, 32'd0, "oor_sel7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
